// File: rtl/iterative_shifter_pkg.sv
// Shared definitions for the iterative shift/rotate engine.
//   - op codes carried on in_op (3 bits)
//   - FSM state encoding
//   - helper to recognise the reserved op codes
package iterative_shifter_pkg;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASL = 3'd2;
  localparam logic [2:0] OP_ASR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;
  // Codes 6 and 7 are reserved.
  localparam logic [2:0] OP_RSV_LO = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_reserved(input logic [2:0] op);
    return (op >= OP_RSV_LO);
  endfunction

endpackage

// File: rtl/iterative_shifter_shift_step_1b.sv
// shift_step_1b: combinational single-bit shift/rotate step.
// Ports:
//   word      - current word
//   op        - op code (iterative_shifter_pkg::OP_*)
//   next_word - word after one step
//   carry     - bit shifted or rotated out by this step
// Reserved op codes pass the word through with carry 0.
module shift_step_1b
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] next_word,
  output logic             carry
);

  always_comb begin
    next_word = word;
    carry     = 1'b0;
    case (op)
      OP_LSL, OP_ASL: begin
        next_word = {word[WIDTH-2:0], 1'b0};
        carry     = word[WIDTH-1];
      end
      OP_LSR: begin
        next_word = {1'b0, word[WIDTH-1:1]};
        carry     = word[0];
      end
      OP_ASR: begin
        next_word = {word[WIDTH-1], word[WIDTH-1:1]};
        carry     = word[0];
      end
      OP_ROL: begin
        next_word = {word[WIDTH-2:0], word[WIDTH-1]};
        carry     = word[WIDTH-1];
      end
      OP_ROR: begin
        next_word = {word[0], word[WIDTH-1:1]};
        carry     = word[0];
      end
      default: begin
        next_word = word;
        carry     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// iterative_shifter: sequential shift/rotate engine, one bit per clock.
// Ports:
//   clk, rst_n             - clock (rising edge), async active-low reset
//   in_valid/in_ready      - operand handshake; in_data, in_op, in_amt
//   out_valid/out_ready    - result handshake; out_data, out_carry, out_err
//   dbg_state              - current FSM state (iterative_shifter_pkg::state_t)
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both 1. in_ready is high only in IDLE, out_valid only in DONE,
// so a result handoff and a new acceptance never share a cycle.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_op,
  input  logic [SHAMT_W-1:0] in_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_err,
  output logic [1:0]         dbg_state
);

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   word;
  logic [2:0]         op;
  logic               carry;
  logic               err;

  logic [WIDTH-1:0]   step_word;
  logic               step_carry;

  logic accept;
  // An op that finishes without any shifting: reserved code or zero amount.
  logic skip_shift;

  assign accept     = (state == ST_IDLE) && in_valid;
  assign skip_shift = is_reserved(in_op) || (in_amt == '0);

  shift_step_1b #(.WIDTH(WIDTH)) u_step (
    .word      (word),
    .op        (op),
    .next_word (step_word),
    .carry     (step_carry)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) state_nxt = skip_shift ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (count == SHAMT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    dbg_state = state;
  end

  // Datapath: held word, op, remaining count, carry and error flag.
  // Amounts >= WIDTH need no special casing: repeating the single-bit
  // step naturally saturates shifts and wraps rotates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      op    <= OP_LSL;
      count <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      word  <= in_data;
      op    <= in_op;
      count <= skip_shift ? '0 : in_amt;
      carry <= 1'b0;
      err   <= is_reserved(in_op);
    end else if (state == ST_SHIFT) begin
      word  <= step_word;
      carry <= step_carry;
      count <= count - SHAMT_W'(1);
    end
  end

  assign out_data  = word;
  assign out_carry = carry;
  assign out_err   = err;

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;

  localparam int WIDTH   = 4;
  localparam int SHAMT_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         in_op;
  logic [SHAMT_W-1:0] in_amt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_err;
  logic [1:0]         dbg_state;

  iterative_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one operand, wait for its result, check it and the latency
  // (edges after the accepting edge), then hand the result off.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] data,
                        input logic [1:0] amt, input logic [3:0] exp_data,
                        input logic exp_carry, input logic exp_err, input int exp_lat);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_data = data; in_amt = amt;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the held operand must not follow.
    in_valid = 1'b0; in_data = ~data; in_op = 3'd7; in_amt = ~amt;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_carry"}, 32'(out_carry), 32'(exp_carry));
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(in_ready), 32'd1);
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    // Operand offered during reset must not be captured.
    in_valid = 1'b1; in_data = 4'b1111; in_op = 3'd0; in_amt = 2'd1;
    @(posedge clk); #1;
    check("rst_no_capture", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("lsl1",   3'd0, 4'b1011, 2'd1, 4'b0110, 1'b1, 1'b0, 1);
    run_op("asr2",   3'd3, 4'b1011, 2'd2, 4'b1110, 1'b1, 1'b0, 2);
    run_op("lsr2",   3'd1, 4'b1011, 2'd2, 4'b0010, 1'b1, 1'b0, 2);
    run_op("rol3",   3'd4, 4'b1001, 2'd3, 4'b1100, 1'b0, 1'b0, 3);
    run_op("ror1",   3'd5, 4'b1001, 2'd1, 4'b1100, 1'b1, 1'b0, 1);
    run_op("rol0",   3'd4, 4'b1001, 2'd0, 4'b1001, 1'b0, 1'b0, 0);
    run_op("asl1",   3'd2, 4'b0110, 2'd1, 4'b1100, 1'b0, 1'b0, 1);
    run_op("asr3",   3'd3, 4'b0101, 2'd3, 4'b0000, 1'b1, 1'b0, 3);
    run_op("rsv6",   3'd6, 4'b0101, 2'd3, 4'b0101, 1'b0, 1'b1, 0);
    run_op("lsl_clr", 3'd0, 4'b0101, 2'd1, 4'b1010, 1'b0, 1'b0, 1);
    run_op("rsv7",   3'd7, 4'b0011, 2'd0, 4'b0011, 1'b0, 1'b1, 0);

    // Backpressure with in_valid held high throughout.
    in_valid = 1'b1; in_op = 3'd0; in_data = 4'b0011; in_amt = 2'd2;
    @(posedge clk); #1;
    in_op = 3'd5; in_data = 4'b0011; in_amt = 2'd1;   // pending next operand
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 32'(out_data), 32'(4'b1100));
      check("bp_hold_carry", 32'(out_carry), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", 32'(in_ready), 32'd1);
    check("bp_no_overlap", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp2_latency", 32'(lat), 32'd1);
    check("bp2_data", 32'(out_data), 32'(4'b1001));
    check("bp2_carry", 32'(out_carry), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset one cycle into ASR 1000 amt 3.
    in_valid = 1'b1; in_op = 3'd3; in_data = 4'b1000; in_amt = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_carry", 32'(out_carry), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    run_op("post_lsr3", 3'd1, 4'b1000, 2'd3, 4'b0001, 1'b0, 1'b0, 3);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
